uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Receive-side deframer for the FFT UART link. Consumes the byte stream from the UART receiver, hunts for the two-byte frame header (0x05, 0x64), and writes the following PAYLOAD_LEN bytes sequentially into a frame buffer through a simple write port. It signals frame completion, aborts partial frames on an inter-byte timeout, and counts good frames. It sits between the UART RX core and the display/analysis buffer on the receiving board.

## Interface
- HDR0, 8'h05, first header byte
- HDR1, 8'h64, second header byte
- PAYLOAD_LEN, 2048, payload bytes per frame (≥2)
- ADDR_W, 11, buffer address width; 2^ADDR_W ≥ PAYLOAD_LEN
- TIMEOUT_CYC, 50000, clk cycles without a byte before an open frame is abandoned (≥2)
- TO_W, 20, timeout counter width; 2^TO_W > TIMEOUT_CYC

- clk  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- uart_rx_done  in  1  one-cycle pulse, uart_rx_data valid
- uart_rx_data  in  8  received byte
- buf_wr_en  out  1  buffer write strobe, one cycle per payload byte
- buf_wr_addr  out  ADDR_W  payload index 0..PAYLOAD_LEN-1
- buf_wr_data  out  8  payload byte
- frame_done  out  1  one-cycle pulse, full frame written
- frame_err  out  1  one-cycle pulse, frame aborted by timeout
- busy  out  1  high while state ≠ S_HUNT0
- frame_cnt  out  16  count of completed frames, wraps 65535→0

## Operation
- All outputs are registered. Reset values: all 0. State S_HUNT0; byte counter and timeout counter 0.
- A byte is "accepted" on a clk edge where uart_rx_done=1. No other input is sampled.
- S_HUNT0: byte==HDR0 → S_HUNT1. Any other byte → stay. Timeout counter held at 0.
- S_HUNT1: byte==HDR1 → S_PAYLOAD, byte counter cleared to 0. byte==HDR0 → stay in S_HUNT1, so 05 05 64 syncs. Any other byte → S_HUNT0. Timeout → S_HUNT0 with no frame_err.
- S_PAYLOAD: each accepted byte is written at address = byte counter, then the counter increments. Bytes equal to HDR0/HDR1 inside the payload are data; no resync occurs. When the byte with counter == PAYLOAD_LEN-1 is accepted: frame_done pulses, frame_cnt increments, → S_HUNT0. Timeout → frame_err pulses, → S_HUNT0. The buffer contents already written are left as-is.
- Timeout counter: cleared on every accepted byte and on entry to S_HUNT1/S_PAYLOAD. Increments each cycle in S_HUNT1/S_PAYLOAD without a byte. Timeout fires when the counter reaches TIMEOUT_CYC-1 with no byte that cycle.
- Simultaneous byte and timeout terminal count: the byte wins and the counter clears.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded silently, with no frame_err.

## Timing
- Latency: byte accepted at edge N → buf_wr_en/addr/data valid for exactly the cycle after edge N (1 clk).
- frame_done and the frame_cnt update are coincident with the last buf_wr_en, at address PAYLOAD_LEN-1.
- frame_err is asserted in the cycle after the timeout edge. buf_wr_en is never high in that cycle.
- The first payload byte may arrive on the cycle immediately after the HDR1 acceptance. Back-to-back uart_rx_done on consecutive cycles is supported: one write per cycle.
- The next frame's HDR0 may arrive on the cycle immediately after the last payload byte and is accepted.
- busy rises the cycle after HDR0 is accepted and falls with frame_done or frame_err.

## Test plan
- Clean frame: 05 64 then payload bytes i mod 256 for i=0..2047 → 2048 writes with addr==i and data==i[7:0], one frame_done coincident with addr 2047, frame_cnt=1, frame_err never high.
- False starts: 33 05 05 64 then a 2048-byte frame → sync on the second 05. Also 05 12 05 64 + frame → sync on the second 05. Both give frame_cnt=1 with correct data.
- Header inside payload: payload bytes 10..11 = 05 64 → no resync, addresses continue contiguously, frame_done at byte 2047.
- Timeout: 05 64 + 100 bytes, then silence for TIMEOUT_CYC cycles → frame_err one pulse, busy=0, frame_cnt unchanged. A following clean frame → frame_done and writes restart at addr 0.
- Back-to-back: two frames with zero idle gap and uart_rx_done every cycle → 4096 writes, two frame_done pulses, frame_cnt=2. Preload frame_cnt to 65535 → wraps to 0.
- Reset mid-payload at byte 500 → all outputs 0 in the same cycle. A following clean frame completes normally with frame_cnt=1.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// Byte-stream input and frame-buffer write port of the UART frame deframer.
// The slave modport is the deframer; the master modport is its environment.
interface uart_frame_rx_if #(
    parameter int ADDR_W = 11
);
    logic              uart_rx_done;
    logic [7:0]        uart_rx_data;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [7:0]        buf_wr_data;
    logic              frame_done;
    logic              frame_err;
    logic              busy;
    logic [15:0]       frame_cnt;

    modport master (
        output uart_rx_done, uart_rx_data,
        input  buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_err, busy, frame_cnt
    );

    modport slave (
        input  uart_rx_done, uart_rx_data,
        output buf_wr_en, buf_wr_addr, buf_wr_data, frame_done, frame_err, busy, frame_cnt
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Receive deframer: hunts for the two-byte header, writes PAYLOAD_LEN bytes to
// the frame buffer, aborts open frames on inter-byte timeout, counts good frames.
module uart_frame_rx #(
    parameter logic [7:0] HDR0        = 8'h05,
    parameter logic [7:0] HDR1        = 8'h64,
    parameter int         PAYLOAD_LEN = 2048,
    parameter int         ADDR_W      = 11,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         TO_W        = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_frame_rx_if.slave   bus
);
    typedef enum logic [1:0] {S_HUNT0, S_HUNT1, S_PAYLOAD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic       byte_v;
    logic [7:0] byte_in;
    logic       to_hit;
    logic       last_byte;

    assign byte_v    = bus.uart_rx_done;
    assign byte_in   = bus.uart_rx_data;
    assign to_hit    = (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign last_byte = (cnt_q == ADDR_W'(PAYLOAD_LEN - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_HUNT0: begin
                to_d = '0;
                if (byte_v && byte_in == HDR0) state_d = S_HUNT1;
            end
            S_HUNT1: begin
                if (byte_v) begin
                    to_d = '0;
                    // A repeated HDR0 keeps us waiting for HDR1 so "05 05 64" still syncs.
                    if (byte_in == HDR1) begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                    end else if (byte_in != HDR0) begin
                        state_d = S_HUNT0;
                    end
                end else if (to_hit) begin
                    state_d = S_HUNT0;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_PAYLOAD: begin
                if (byte_v) begin
                    to_d      = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = byte_in;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (last_byte) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_HUNT0;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HUNT0;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: begin
                state_d = S_HUNT0;
                to_d    = '0;
            end
        endcase

        busy_d = (state_d != S_HUNT0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT0;
            cnt_q       <= '0;
            to_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.buf_wr_data = wr_data_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = busy_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized bench for uart_frame_rx; expected writes come from the payload
// arrays each scenario sends, not from any model of the receiver's states.
module tb_uart_frame_rx;
    localparam int         LEN  = 2048;
    localparam int         AW   = 11;
    localparam int         TO   = 300;
    localparam int         TW   = 12;
    localparam logic [7:0] H0   = 8'h05;
    localparam logic [7:0] H1   = 8'h64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_rx_if #(.ADDR_W(AW)) bus ();

    uart_frame_rx #(
        .HDR0(H0), .HDR1(H1), .PAYLOAD_LEN(LEN), .ADDR_W(AW),
        .TIMEOUT_CYC(TO), .TO_W(TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;
    int exp_cnt = 0;
    logic [7:0] pay [2][LEN];

    // Observed traffic: each write as addr*256+data, plus pulse counts.
    int wr_q[$];
    int n_done, n_err, n_bad;

    always @(negedge clk) if (rst_n) begin
        if (bus.buf_wr_en) wr_q.push_back(int'(bus.buf_wr_addr) * 256 + int'(bus.buf_wr_data));
        if (bus.frame_done) begin
            n_done++;
            if (!bus.buf_wr_en || int'(bus.buf_wr_addr) != LEN - 1) n_bad++;
        end
        if (bus.frame_err) begin
            n_err++;
            if (bus.buf_wr_en) n_bad++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_q.delete();
        n_done = 0; n_err = 0; n_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin @(negedge clk); bus.uart_rx_done = 1'b0; end
        @(negedge clk); bus.uart_rx_done = 1'b1; bus.uart_rx_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); bus.uart_rx_done = 1'b0; end
    endtask

    task automatic send_frame(input int f, input int maxgap);
        send_byte(H0, $urandom_range(maxgap, 0));
        send_byte(H1, $urandom_range(maxgap, 0));
        for (int i = 0; i < LEN; i++) send_byte(pay[f][i], $urandom_range(maxgap, 0));
    endtask

    task automatic fill_rand(input int f);
        for (int i = 0; i < LEN; i++) pay[f][i] = 8'($urandom);
    endtask

    task automatic test_reset();
        bus.uart_rx_done = 1'b0; bus.uart_rx_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nchk++;
        if ({bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done, bus.frame_err, bus.busy} !== '0) begin
            nerr++; $display("FAIL reset_outs: got wr_en=%b addr=%0d data=%0h done=%b err=%b busy=%b want all 0",
                bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done, bus.frame_err, bus.busy);
        end
        nchk++;
        if (bus.frame_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", bus.frame_cnt); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_clean();
        int bad;
        for (int i = 0; i < LEN; i++) pay[0][i] = 8'(i);
        clear_mon();
        send_byte(H0, 0);
        idle(1);
        nchk++;
        if (bus.busy !== 1'b1) begin nerr++; $display("FAIL clean_busy_rise: got %b want 1", bus.busy); end
        send_byte(H1, 0);
        for (int i = 0; i < LEN; i++) send_byte(pay[0][i], $urandom_range(2, 0));
        idle(4);
        exp_cnt = (exp_cnt + 1) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != LEN) begin nerr++; $display("FAIL clean_nwr: got %0d want %0d", wr_q.size(), LEN); end
        nchk++; if (bad != -1) begin nerr++; $display("FAIL clean_data: write %0d got %0h want %0h", bad, wr_q[bad], bad * 256 + int'(pay[0][bad])); end
        nchk++; if (n_done != 1 || n_err != 0 || n_bad != 0) begin nerr++; $display("FAIL clean_pulses: got done=%0d err=%0d bad=%0d want 1 0 0", n_done, n_err, n_bad); end
        nchk++; if (int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL clean_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
        nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL clean_busy_fall: got %b want 0", bus.busy); end
    endtask

    task automatic test_false_start();
        logic [7:0] pre [2][2];
        int bad;
        pre[0][0] = 8'h33; pre[0][1] = H0;
        pre[1][0] = H0;    pre[1][1] = 8'h12;
        for (int c = 0; c < 2; c++) begin
            fill_rand(0);
            clear_mon();
            send_byte(pre[c][0], 0);
            send_byte(pre[c][1], 1);
            send_frame(0, 2);
            idle(4);
            exp_cnt = (exp_cnt + 1) % 65536;
            bad = -1;
            for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
            nchk++; if (wr_q.size() != LEN || bad != -1) begin nerr++; $display("FAIL false_start%0d_data: got nwr=%0d bad_at=%0d want nwr=%0d bad_at=-1", c, wr_q.size(), bad, LEN); end
            nchk++; if (n_done != 1 || n_err != 0 || n_bad != 0) begin nerr++; $display("FAIL false_start%0d_pulses: got done=%0d err=%0d bad=%0d want 1 0 0", c, n_done, n_err, n_bad); end
            nchk++; if (int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL false_start%0d_cnt: got %0d want %0d", c, bus.frame_cnt, exp_cnt); end
        end
    endtask

    task automatic test_hdr_in_payload();
        int bad;
        fill_rand(0);
        pay[0][10] = H0; pay[0][11] = H1;
        clear_mon();
        send_frame(0, 0);
        idle(4);
        exp_cnt = (exp_cnt + 1) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != LEN || bad != -1) begin nerr++; $display("FAIL hdr_payload_data: got nwr=%0d bad_at=%0d want nwr=%0d bad_at=-1", wr_q.size(), bad, LEN); end
        nchk++; if (n_done != 1 || n_bad != 0 || int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL hdr_payload_done: got done=%0d bad=%0d cnt=%0d want 1 0 %0d", n_done, n_bad, bus.frame_cnt, exp_cnt); end
    endtask

    task automatic test_timeout_boundary();
        int bad;
        // HDR0 then silence long enough to time out: the late HDR1 must not open a frame.
        clear_mon();
        send_byte(H0, 0);
        send_byte(H1, TO);
        for (int i = 0; i < 10; i++) send_byte(8'h20 + 8'(i), 0);
        idle(4);
        nchk++; if (wr_q.size() != 0 || n_err != 0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL hunt1_timeout: got nwr=%0d err=%0d busy=%b want 0 0 0", wr_q.size(), n_err, bus.busy); end
        // A gap one cycle short of the timeout must not abort the frame.
        fill_rand(0);
        clear_mon();
        send_byte(H0, 0);
        send_byte(H1, 0);
        for (int i = 0; i < LEN; i++) send_byte(pay[0][i], (i == 700) ? TO - 1 : 0);
        idle(4);
        exp_cnt = (exp_cnt + 1) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != LEN || bad != -1 || n_err != 0 || n_done != 1) begin nerr++; $display("FAIL gap_below_timeout: got nwr=%0d bad_at=%0d err=%0d done=%0d want %0d -1 0 1", wr_q.size(), bad, n_err, n_done, LEN); end
    endtask

    task automatic test_timeout();
        int bad;
        fill_rand(0);
        clear_mon();
        send_byte(H0, 0);
        send_byte(H1, 0);
        for (int i = 0; i < 100; i++) send_byte(pay[0][i], $urandom_range(3, 0));
        idle(TO);
        nchk++; if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin nerr++; $display("FAIL timeout_early: got busy=%b err=%b want 1 0", bus.busy, bus.frame_err); end
        idle(1);
        nchk++; if (bus.busy !== 1'b0 || bus.frame_err !== 1'b1 || bus.buf_wr_en !== 1'b0) begin nerr++; $display("FAIL timeout_edge: got busy=%b err=%b wr_en=%b want 0 1 0", bus.busy, bus.frame_err, bus.buf_wr_en); end
        idle(4);
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < 100; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != 100 || bad != -1) begin nerr++; $display("FAIL timeout_writes: got nwr=%0d bad_at=%0d want 100 -1", wr_q.size(), bad); end
        nchk++; if (n_err != 1 || n_done != 0 || n_bad != 0 || int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL timeout_pulses: got err=%0d done=%0d bad=%0d cnt=%0d want 1 0 0 %0d", n_err, n_done, n_bad, bus.frame_cnt, exp_cnt); end
        fill_rand(0);
        clear_mon();
        send_frame(0, 1);
        idle(4);
        exp_cnt = (exp_cnt + 1) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != LEN || bad != -1 || n_done != 1 || int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL timeout_recover: got nwr=%0d bad_at=%0d done=%0d cnt=%0d want %0d -1 1 %0d", wr_q.size(), bad, n_done, bus.frame_cnt, LEN, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int bad;
        fill_rand(0);
        fill_rand(1);
        clear_mon();
        send_frame(0, 0);
        send_frame(1, 0);
        idle(4);
        exp_cnt = (exp_cnt + 2) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < 2 * LEN; i++)
            if (bad < 0 && wr_q[i] != (i % LEN) * 256 + int'(pay[i / LEN][i % LEN])) bad = i;
        nchk++; if (wr_q.size() != 2 * LEN || bad != -1) begin nerr++; $display("FAIL b2b_data: got nwr=%0d bad_at=%0d want %0d -1", wr_q.size(), bad, 2 * LEN); end
        nchk++; if (n_done != 2 || n_err != 0 || n_bad != 0) begin nerr++; $display("FAIL b2b_pulses: got done=%0d err=%0d bad=%0d want 2 0 0", n_done, n_err, n_bad); end
        nchk++; if (int'(bus.frame_cnt) != exp_cnt) begin nerr++; $display("FAIL b2b_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hffff;
        #1;
        release dut.frame_cnt_q;
        idle(1);
        nchk++; if (bus.frame_cnt !== 16'hffff) begin nerr++; $display("FAIL wrap_preload: got %0d want 65535", bus.frame_cnt); end
        fill_rand(0);
        clear_mon();
        send_frame(0, 0);
        idle(4);
        exp_cnt = 0;
        nchk++; if (bus.frame_cnt !== 16'd0 || n_done != 1) begin nerr++; $display("FAIL wrap_cnt: got cnt=%0d done=%0d want 0 1", bus.frame_cnt, n_done); end
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_rand(0);
        clear_mon();
        send_byte(H0, 0);
        send_byte(H1, 0);
        for (int i = 0; i < 500; i++) send_byte(pay[0][i], 0);
        idle(1);
        nchk++; if (bus.busy !== 1'b1 || bus.buf_wr_en !== 1'b1) begin nerr++; $display("FAIL rstmid_pre: got busy=%b wr_en=%b want 1 1", bus.busy, bus.buf_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done, bus.frame_err, bus.busy, bus.frame_cnt} !== '0) begin
            nerr++; $display("FAIL rstmid_outs: got wr_en=%b addr=%0d data=%0h done=%b err=%b busy=%b cnt=%0d want all 0",
                bus.buf_wr_en, bus.buf_wr_addr, bus.buf_wr_data, bus.frame_done, bus.frame_err, bus.busy, bus.frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        idle(2);
        clear_mon();
        send_frame(0, 1);
        idle(4);
        exp_cnt = (exp_cnt + 1) % 65536;
        bad = -1;
        for (int i = 0; i < wr_q.size() && i < LEN; i++) if (bad < 0 && wr_q[i] != i * 256 + int'(pay[0][i])) bad = i;
        nchk++; if (wr_q.size() != LEN || bad != -1 || n_err != 0) begin nerr++; $display("FAIL rstmid_frame: got nwr=%0d bad_at=%0d err=%0d want %0d -1 0", wr_q.size(), bad, n_err, LEN); end
        nchk++; if (int'(bus.frame_cnt) != exp_cnt || n_done != 1) begin nerr++; $display("FAIL rstmid_cnt: got cnt=%0d done=%0d want %0d 1", bus.frame_cnt, n_done, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_false_start();
        test_hdr_in_payload();
        test_timeout_boundary();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
